aes_gcm_round_stage: RTL and testbench
======================================

# aes_gcm_round_stage

Parametrised, iterative AES round engine for the AES-GCM datapath. It applies a configurable window of AES rounds (FIRST_ROUND .. FIRST_ROUND+NUM_ROUNDS-1) to up to NUM_LANES independent 128-bit lanes (H, J0, CB, ...) under one shared key schedule. A valid/ready handshake replaces the free-running stage registers. Sideband fields (phase, plaintext, AAD, sizes) ride along unchanged, so a chain of these stages replaces the fixed per-stage pipeline modules.

## Interface
- NUM_LANES, 3, number of 128-bit lanes processed per transaction
- FIRST_ROUND, 1, index of first round applied (0..10)
- NUM_ROUNDS, 3, rounds applied per transaction; FIRST_ROUND+NUM_ROUNDS <= 11
- ROUNDS_PER_CYCLE, 1, rounds unrolled per clock; NUM_ROUNDS % ROUNDS_PER_CYCLE == 0
- SIDEBAND_W, 387, width of pass-through sideband bus
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  upstream transaction valid
- o_ready  output  1  stage can accept a transaction this cycle
- i_lane_en  input  NUM_LANES  per-lane enable; disabled lanes pass through unmodified
- i_lanes  input  [0:NUM_LANES*128-1]  lane states, lane k at bits [128k +: 128]
- i_key_schedule  input  [0:1407]  11 round keys, key r at bits [128r +: 128]
- i_sideband  input  SIDEBAND_W  pass-through data
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_lanes, o_lane_en, o_key_schedule, o_sideband  output  same widths as inputs  registered results
- o_busy  output  1  high in CALC
- o_txn_count  output  32  completed-transaction counter (only with AES_GCM_STAGE_CNT_EN)

## Operation
- Round r semantics: r=0 AddRoundKey only; r=1..9 SubBytes, ShiftRows, MixColumns, AddRoundKey(key r); r=10 omits MixColumns. Standard FIPS-197 byte order, byte 0 = bits [0:7].
- ITER = NUM_ROUNDS / ROUNDS_PER_CYCLE.
- FSM states: IDLE, CALC, DONE.
  - IDLE: o_ready=1. On i_valid, capture lanes, lane_en, key schedule, and sideband. Set round counter to FIRST_ROUND, iteration counter to 0, and move to CALC.
  - CALC: o_ready=0. Each cycle, apply ROUNDS_PER_CYCLE consecutive rounds to enabled lanes. Advance the round counter by ROUNDS_PER_CYCLE. After the ITER-th cycle, move to DONE.
  - DONE: o_valid=1, and outputs are held stable until i_ready. o_ready = i_ready.
    - i_ready && i_valid: capture the new transaction and go to CALC (back-to-back).
    - i_ready && !i_valid: go to IDLE.
- Key schedule and sideband are captured once per transaction and are never re-sampled mid-transaction.
- Lanes with i_lane_en=0 leave unchanged. o_lane_en echoes the captured mask.
- Reset (asynchronous, any state, including mid-CALC): state IDLE, o_valid=0, o_busy=0, all data registers and counters 0, o_txn_count 0. An in-flight transaction is discarded.

## Timing
- Accept edge: i_valid && o_ready at rising edge T.
- o_valid rises after edge T+ITER and is high in cycle T+ITER.
- Back-to-back throughput: one transaction per ITER+1 cycles.
- o_ready is combinational from i_ready and state only, never from i_valid.
- All data outputs are registers. No combinational path from inputs to o_lanes.
- Stall: while o_valid && !i_ready, all outputs are held bit-stable.

## Configuration
- AES_GCM_STAGE_CNT_EN defined: o_txn_count increments by 1 on each o_valid && i_ready. It wraps 0xFFFFFFFF -> 0 and resets to 0.
- AES_GCM_STAGE_CNT_EN undefined: port o_txn_count and its counter are absent. Behaviour is otherwise identical.

## Test plan
- FIRST_ROUND=0, NUM_ROUNDS=11, key 000102..0f, lane0 00112233445566778899aabbccddeeff, lane_en=001 -> o_valid at cycle T+11, lane0 = 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIRST_ROUND=0, NUM_ROUNDS=2, ROUNDS_PER_CYCLE=2, same vector -> o_valid at T+1, lane0 = 89d810e8855ace682d1843d8cb128fe4.
- Same vector in lanes 0 and 2, lane_en=101, lane1=0xdeadbeef.. -> lanes 0/2 encrypted identically, lane1 unchanged, sideband pattern echoed bit-exact.
- Hold i_ready=0 for 5 cycles in DONE while i_valid=1 -> outputs stable, o_ready=0. Raise i_ready -> second transaction accepted same edge, its o_valid ITER cycles later.
- Assert rst_n=0 mid-CALC -> o_valid=0 and o_ready=1 immediately after release, no stale output, o_txn_count=0.
- With AES_GCM_STAGE_CNT_EN: 3 completed handshakes -> o_txn_count=3. Preload near 0xFFFFFFFF by force -> wraps to 0.

Source files
------------

// File: rtl/aes_gcm_round_stage.sv
// Iterative AES round window (FIRST_ROUND..FIRST_ROUND+NUM_ROUNDS-1) over NUM_LANES lanes, valid/ready handshake.
// Define AES_GCM_STAGE_CNT_EN to add the completed-transaction counter on o_txn_count.

module aes_gcm_round_lane #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic [127:0]                        state,
    input  logic [3:0]                          round,
    input  logic [ROUNDS_PER_CYCLE-1:0][127:0]  keys,
    output logic [127:0]                        result
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state lives at [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] do_round(input logic [127:0] s, input logic [3:0] r,
                                              input logic [127:0] k);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[rr+4*c] = b[rr + 4*((c+rr)%4)];
        if (r != 4'd10) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return (r == 4'd0) ? (s ^ k) : (o ^ k);
    endfunction

    always_comb begin
        result = state;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++)
            result = do_round(result, round + 4'(j), keys[j]);
    end
endmodule

module aes_gcm_round_stage #(
    parameter int NUM_LANES        = 3,
    parameter int FIRST_ROUND      = 1,
    parameter int NUM_ROUNDS       = 3,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int SIDEBAND_W       = 387
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [NUM_LANES-1:0]        i_lane_en,
    input  logic [0:NUM_LANES*128-1]    i_lanes,
    input  logic [0:1407]               i_key_schedule,
    input  logic [SIDEBAND_W-1:0]       i_sideband,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [0:NUM_LANES*128-1]    o_lanes,
    output logic [NUM_LANES-1:0]        o_lane_en,
    output logic [0:1407]               o_key_schedule,
    output logic [SIDEBAND_W-1:0]       o_sideband,
`ifdef AES_GCM_STAGE_CNT_EN
    output logic [31:0]                 o_txn_count,
`endif
    output logic                        o_busy
);
    localparam int ITER = NUM_ROUNDS / ROUNDS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                             state_q, state_d;
    logic                               accept, step;
    logic [NUM_LANES-1:0][127:0]        lanes_q, lane_next;
    logic [NUM_LANES-1:0]               lane_en_q;
    logic [0:1407]                      key_q;
    logic [SIDEBAND_W-1:0]              sb_q;
    logic [3:0]                         round_q, iter_q;
    logic [127:0]                       key_arr [16];
    logic [ROUNDS_PER_CYCLE-1:0][127:0] round_keys;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // o_ready depends only on state and i_ready so it never loops back through i_valid.
    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                o_busy = 1'b1;
                step   = 1'b1;
                if (iter_q == 4'(ITER-1)) state_d = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                o_ready = i_ready;
                if (i_ready) begin
                    if (i_valid) begin
                        accept  = 1'b1;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q   <= '0;
            lane_en_q <= '0;
            key_q     <= '0;
            sb_q      <= '0;
            round_q   <= '0;
            iter_q    <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_LANES; k++) lanes_q[k] <= i_lanes[128*k +: 128];
            lane_en_q <= i_lane_en;
            key_q     <= i_key_schedule;
            sb_q      <= i_sideband;
            round_q   <= 4'(FIRST_ROUND);
            iter_q    <= '0;
        end else if (step) begin
            for (int k = 0; k < NUM_LANES; k++)
                if (lane_en_q[k]) lanes_q[k] <= lane_next[k];
            round_q <= round_q + 4'(ROUNDS_PER_CYCLE);
            iter_q  <= iter_q + 4'd1;
        end
    end

    // Indices 11..15 are unreachable for legal parameters; tie them off so the select is total.
    for (genvar r = 0; r < 16; r++) begin : g_key
        if (r <= 10) begin : g_real
            assign key_arr[r] = key_q[128*r +: 128];
        end else begin : g_pad
            assign key_arr[r] = '0;
        end
    end

    always_comb begin
        round_keys = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) round_keys[j] = key_arr[round_q + 4'(j)];
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        aes_gcm_round_lane #(.ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)) u_lane (
            .state  (lanes_q[k]),
            .round  (round_q),
            .keys   (round_keys),
            .result (lane_next[k])
        );
        assign o_lanes[128*k +: 128] = lanes_q[k];
    end

    assign o_lane_en      = lane_en_q;
    assign o_key_schedule = key_q;
    assign o_sideband     = sb_q;

`ifdef AES_GCM_STAGE_CNT_EN
    logic [31:0] txn_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         txn_q <= '0;
        else if (state_q == DONE && i_ready) txn_q <= txn_q + 32'd1;
    end
    assign o_txn_count = txn_q;
`endif
endmodule

// File: tb/tb_aes_gcm_round_stage.sv
// Bench for aes_gcm_round_stage: three round-window configurations against a byte-level AES model.
module tb_aes_gcm_round_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]   lane_en;
    logic [0:383] lanes;
    logic [0:1407] ks;
    logic [386:0] sb;
    logic         v [3];
    logic         r [3];
    logic         ordy [3];
    logic         ov [3];
    logic         obusy [3];
    logic [0:383] olanes [3];
    logic [2:0]   oen [3];
    logic [0:1407] oks [3];
    logic [386:0] osb [3];
`ifdef AES_GCM_STAGE_CNT_EN
    logic [31:0]  cnt [3];
`endif

    // Configurations: dut0 full AES-128, dut1 rounds 0..1 two per cycle, dut2 rounds 7..10 two per cycle.
    int FR [3] = '{0, 0, 7};
    int NR [3] = '{11, 2, 4};
    int IT [3] = '{11, 1, 2};

    aes_gcm_round_stage #(.NUM_LANES(3), .FIRST_ROUND(0), .NUM_ROUNDS(11), .ROUNDS_PER_CYCLE(1),
                          .SIDEBAND_W(387)) u0 (
        .clk(clk), .rst_n(rst_n), .i_valid(v[0]), .o_ready(ordy[0]), .i_lane_en(lane_en),
        .i_lanes(lanes), .i_key_schedule(ks), .i_sideband(sb), .o_valid(ov[0]), .i_ready(r[0]),
        .o_lanes(olanes[0]), .o_lane_en(oen[0]), .o_key_schedule(oks[0]), .o_sideband(osb[0]),
`ifdef AES_GCM_STAGE_CNT_EN
        .o_txn_count(cnt[0]),
`endif
        .o_busy(obusy[0]));
    aes_gcm_round_stage #(.NUM_LANES(3), .FIRST_ROUND(0), .NUM_ROUNDS(2), .ROUNDS_PER_CYCLE(2),
                          .SIDEBAND_W(387)) u1 (
        .clk(clk), .rst_n(rst_n), .i_valid(v[1]), .o_ready(ordy[1]), .i_lane_en(lane_en),
        .i_lanes(lanes), .i_key_schedule(ks), .i_sideband(sb), .o_valid(ov[1]), .i_ready(r[1]),
        .o_lanes(olanes[1]), .o_lane_en(oen[1]), .o_key_schedule(oks[1]), .o_sideband(osb[1]),
`ifdef AES_GCM_STAGE_CNT_EN
        .o_txn_count(cnt[1]),
`endif
        .o_busy(obusy[1]));
    aes_gcm_round_stage #(.NUM_LANES(3), .FIRST_ROUND(7), .NUM_ROUNDS(4), .ROUNDS_PER_CYCLE(2),
                          .SIDEBAND_W(387)) u2 (
        .clk(clk), .rst_n(rst_n), .i_valid(v[2]), .o_ready(ordy[2]), .i_lane_en(lane_en),
        .i_lanes(lanes), .i_key_schedule(ks), .i_sideband(sb), .o_valid(ov[2]), .i_ready(r[2]),
        .o_lanes(olanes[2]), .o_lane_en(oen[2]), .o_key_schedule(oks[2]), .o_sideband(osb[2]),
`ifdef AES_GCM_STAGE_CNT_EN
        .o_txn_count(cnt[2]),
`endif
        .o_busy(obusy[2]));

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0]  sbt [256];
    logic [31:0] exp_cnt [3];
    logic [0:383] exp_l;
    logic [0:1407] exp_k;
    logic [2:0]   exp_e;
    logic [386:0] exp_s;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from the multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [0:1407] expand(input logic [127:0] key);
        logic [7:0] w [44][4];
        logic [7:0] t [4];
        logic [7:0] tmp, rc;
        logic [0:1407] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[127-8*(4*i+j) -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = tmp;
                for (int j = 0; j < 4; j++) t[j] = sbt[t[j]];
                t[0] ^= rc;
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int i = 0; i < 44; i++)
            for (int j = 0; j < 4; j++) o[32*i + 8*j +: 8] = w[i][j];
        return o;
    endfunction

    // State kept as a 4x4 matrix s[row][col]; rounds follow FIPS-197 directly.
    function automatic logic [127:0] ref_enc(input logic [127:0] din, input int first, input int num,
                                             input logic [0:1407] k);
        logic [7:0] s [4][4];
        logic [7:0] c0, c1, c2, c3, tmp;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i%4][i/4] = din[127-8*i -: 8];
        for (int rn = first; rn < first + num; rn++) begin
            if (rn > 0) begin
                for (int a = 0; a < 4; a++)
                    for (int b = 0; b < 4; b++) s[a][b] = sbt[s[a][b]];
                for (int row = 1; row < 4; row++)
                    repeat (row) begin
                        tmp = s[row][0]; s[row][0] = s[row][1]; s[row][1] = s[row][2];
                        s[row][2] = s[row][3]; s[row][3] = tmp;
                    end
                if (rn < 10)
                    for (int col = 0; col < 4; col++) begin
                        c0 = s[0][col]; c1 = s[1][col]; c2 = s[2][col]; c3 = s[3][col];
                        s[0][col] = gmul(8'h02, c0) ^ gmul(8'h03, c1) ^ c2 ^ c3;
                        s[1][col] = c0 ^ gmul(8'h02, c1) ^ gmul(8'h03, c2) ^ c3;
                        s[2][col] = c0 ^ c1 ^ gmul(8'h02, c2) ^ gmul(8'h03, c3);
                        s[3][col] = gmul(8'h03, c0) ^ c1 ^ c2 ^ gmul(8'h02, c3);
                    end
            end
            for (int i = 0; i < 16; i++) s[i%4][i/4] ^= k[128*rn + 8*i +: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i%4][i/4];
        return o;
    endfunction

    task automatic prep(input int d, input logic [127:0] key, input logic [2:0][127:0] ln,
                        input logic [2:0] en, input logic [386:0] side);
        ks = expand(key);
        lane_en = en;
        sb = side;
        for (int k = 0; k < 3; k++) begin
            lanes[128*k +: 128] = ln[k];
            exp_l[128*k +: 128] = en[k] ? ref_enc(ln[k], FR[d], NR[d], ks) : ln[k];
        end
        exp_k = ks; exp_e = en; exp_s = side;
    endtask

    task automatic start(input int d);
        @(negedge clk);
        chk("ready_when_idle", 512'(ordy[d]), 512'(1));
        v[d] = 1'b1;
        @(posedge clk); #1;
        v[d] = 1'b0;
        chk("busy_after_accept", 512'(obusy[d]), 512'(1));
    endtask

    task automatic wait_valid(input int d, input int exp_lat);
        int lat;
        lat = 0;
        while (ov[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("valid_latency", 512'(lat), 512'(exp_lat));
    endtask

    task automatic check_out(input int d);
        chk("lanes", 512'(olanes[d]), 512'(exp_l));
        chk("lane_en", 512'(oen[d]), 512'(exp_e));
        chk("sideband", 512'(osb[d]), 512'(exp_s));
        chk("key_sched_a", 512'(oks[d][0 +: 512]), 512'(exp_k[0 +: 512]));
        chk("key_sched_b", 512'(oks[d][512 +: 512]), 512'(exp_k[512 +: 512]));
        chk("key_sched_c", 512'(oks[d][1024 +: 384]), 512'(exp_k[1024 +: 384]));
    endtask

    task automatic finish_txn(input int d);
        @(negedge clk);
        r[d] = 1'b1;
        @(posedge clk); #1;
        r[d] = 1'b0;
        exp_cnt[d] = exp_cnt[d] + 32'd1;
        chk("valid_drop_after_handshake", 512'(ov[d]), 512'(0));
    endtask

    typedef struct {
        int               d;
        logic [127:0]     key;
        logic [2:0][127:0] ln;
        logic [2:0]       en;
        logic [2:0][127:0] ex;
    } vec_t;
    vec_t vt [5];

    task automatic set_vec(input int i, input int d, input logic [127:0] key, input logic [127:0] l0,
                           input logic [127:0] l1, input logic [127:0] l2, input logic [2:0] en,
                           input logic [127:0] e0, input logic [127:0] e1, input logic [127:0] e2);
        vt[i].d = d; vt[i].key = key; vt[i].en = en;
        vt[i].ln[0] = l0; vt[i].ln[1] = l1; vt[i].ln[2] = l2;
        vt[i].ex[0] = e0; vt[i].ex[1] = e1; vt[i].ex[2] = e2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] K1, P1, C1, DB;
        logic [2:0][127:0] rl;
        logic [415:0] rsb;
        logic [386:0] pat;
        logic [0:383] exp_a;
        logic [386:0] sb_a;

        K1 = 128'h000102030405060708090a0b0c0d0e0f;
        P1 = 128'h00112233445566778899aabbccddeeff;
        C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        DB = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        set_vec(0, 0, K1, P1, '0, '0, 3'b001, C1, '0, '0);
        set_vec(1, 1, K1, P1, '0, '0, 3'b001, 128'h89d810e8855ace682d1843d8cb128fe4, '0, '0);
        set_vec(2, 0, K1, P1, DB, P1, 3'b101, C1, DB, C1);
        set_vec(3, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210,
                128'h3243f6a8885a308d313198a2e0370734, '0, 3'b010,
                128'h0123456789abcdeffedcba9876543210, 128'h3925841d02dc09fbdc118597196a0b32, '0);
        set_vec(4, 1, K1, 128'h55aa55aa00ff00ff11223344cafef00d, P1, DB, 3'b000,
                128'h55aa55aa00ff00ff11223344cafef00d, P1, DB);
        pat = {13{32'ha5c30f96}};

        build_sbox();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin v[d] = 1'b0; r[d] = 1'b0; exp_cnt[d] = '0; end
        lanes = {3{DB}}; lane_en = 3'b111; ks = '1; sb = pat;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 512'(ov[0]), 512'(0));
        chk("reset_ready", 512'(ordy[0]), 512'(1));
        chk("reset_busy", 512'(obusy[0]), 512'(0));
        chk("reset_lanes", 512'(olanes[0]), 512'(0));
        chk("reset_sideband", 512'(osb[2]), 512'(0));
`ifdef AES_GCM_STAGE_CNT_EN
        chk("reset_count", 512'(cnt[0]), 512'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer table
        for (int i = 0; i < 5; i++) begin
            prep(vt[i].d, vt[i].key, vt[i].ln, vt[i].en, pat);
            for (int k = 0; k < 3; k++) exp_l[128*k +: 128] = vt[i].ex[k];
            start(vt[i].d);
            wait_valid(vt[i].d, IT[vt[i].d]);
            check_out(vt[i].d);
            finish_txn(vt[i].d);
        end

        // Randomised transactions against the model
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 6; n++) begin
                for (int k = 0; k < 3; k++) rl[k] = {$urandom, $urandom, $urandom, $urandom};
                for (int q = 0; q < 13; q++) rsb[32*q +: 32] = $urandom;
                prep(d, {$urandom, $urandom, $urandom, $urandom}, rl, 3'($urandom_range(0, 7)),
                     rsb[386:0]);
                start(d);
                wait_valid(d, IT[d]);
                check_out(d);
                finish_txn(d);
            end
        end

        // Stall in DONE with the next transaction waiting, then back-to-back accept
        for (int k = 0; k < 3; k++) rl[k] = {$urandom, $urandom, $urandom, $urandom};
        prep(2, {$urandom, $urandom, $urandom, $urandom}, rl, 3'b111, ~pat);
        exp_a = exp_l; sb_a = exp_s;
        start(2);
        wait_valid(2, IT[2]);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rl[k] = {$urandom, $urandom, $urandom, $urandom};
        prep(2, {$urandom, $urandom, $urandom, $urandom}, rl, 3'b011, pat);
        v[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 512'(ov[2]), 512'(1));
            chk("stall_ready", 512'(ordy[2]), 512'(0));
            chk("stall_lanes", 512'(olanes[2]), 512'(exp_a));
            chk("stall_sideband", 512'(osb[2]), 512'(sb_a));
            @(negedge clk);
        end
        r[2] = 1'b1;
        #1;
        chk("ready_follows_i_ready", 512'(ordy[2]), 512'(1));
        @(posedge clk); #1;
        v[2] = 1'b0; r[2] = 1'b0;
        exp_cnt[2] = exp_cnt[2] + 32'd1;
        chk("b2b_valid_drop", 512'(ov[2]), 512'(0));
        chk("b2b_busy", 512'(obusy[2]), 512'(1));
        wait_valid(2, IT[2]);
        check_out(2);
        finish_txn(2);

`ifdef AES_GCM_STAGE_CNT_EN
        for (int d = 0; d < 3; d++) chk("txn_count", 512'(cnt[d]), 512'(exp_cnt[d]));
        force u0.txn_q = 32'hFFFFFFFE;
        #1;
        release u0.txn_q;
        exp_cnt[0] = 32'hFFFFFFFE;
        for (int n = 0; n < 2; n++) begin
            prep(0, K1, {P1, P1, P1}, 3'b001, pat);
            start(0); wait_valid(0, IT[0]); finish_txn(0);
        end
        chk("txn_count_wrap", 512'(cnt[0]), 512'(exp_cnt[0]));
`endif

        // Reset in the middle of CALC discards the transaction
        prep(0, K1, {P1, P1, P1}, 3'b111, pat);
        start(0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 512'(ov[0]), 512'(0));
        chk("midreset_busy", 512'(obusy[0]), 512'(0));
        chk("midreset_ready", 512'(ordy[0]), 512'(1));
        chk("midreset_lanes", 512'(olanes[0]), 512'(0));
`ifdef AES_GCM_STAGE_CNT_EN
        chk("midreset_count", 512'(cnt[0]), 512'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("no_stale_valid", 512'(ov[0]), 512'(0));
        chk("ready_after_reset", 512'(ordy[0]), 512'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
